// File: rtl/shift_rx_pkg.sv
// Shared types for the shift-link receiver.
// Holds the FSM state enum and the default synchronizer depth.
package shift_rx_pkg;

    typedef enum logic {
        RX_IDLE  = 1'b0,
        RX_SHIFT = 1'b1
    } rx_state_t;

    localparam int SYNC_STAGES_DEFAULT = 2;

endpackage

// File: rtl/shift_receiver_sync_edge.sv
// Multi-flop synchronizer with a history flop for edge detection.
// Edge outputs are valid for exactly one i_clk cycle.
module sync_edge
    import shift_rx_pkg::*;
#(
    parameter int   SYNC_STAGES = SYNC_STAGES_DEFAULT,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= {SYNC_STAGES{RST_VAL}};
            r_hist <= RST_VAL;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = o_level & ~r_hist;
    assign o_fall  = ~o_level & r_hist;

endmodule

// File: rtl/shift_receiver.sv
// Serial-to-parallel responder for the 3-wire shift link, valid/ready output.
// Define SHIFT_RX_REPLY_EN to add the tx_data_in/sdata_out reply path.
module shift_receiver
    import shift_rx_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic             sclk_in,
    input  logic             cs_n_in,
    input  logic             sdata_in,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid_out,
    input  logic             data_ready_in,
    output logic             overrun_out,
    output logic             busy_out
`ifdef SHIFT_RX_REPLY_EN
    ,
    input  logic [WIDTH-1:0] tx_data_in,
    output logic             sdata_out
`endif
);

    localparam int            CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    rx_state_t        r_state;
    rx_state_t        w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_hold;
    logic             r_valid;
    logic             r_ovr;

    logic w_sclk_lvl;
    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_cs_lvl;
    logic w_cs_rise;
    logic w_cs_fall;
    logic w_sd;
    logic w_sd_rise;
    logic w_sd_fall;
    logic w_done;
    logic w_sample;
    logic w_accept;
    logic w_unused_bits;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .i_clk   (clk_in),
        .i_rst_n (reset_in),
        .i_async (sclk_in),
        .o_level (w_sclk_lvl),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    // cs_n idles high, so reset its synchronizer high to avoid a false edge.
    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
        .i_clk   (clk_in),
        .i_rst_n (reset_in),
        .i_async (cs_n_in),
        .o_level (w_cs_lvl),
        .o_rise  (w_cs_rise),
        .o_fall  (w_cs_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sd (
        .i_clk   (clk_in),
        .i_rst_n (reset_in),
        .i_async (sdata_in),
        .o_level (w_sd),
        .o_rise  (w_sd_rise),
        .o_fall  (w_sd_fall)
    );

`ifdef SHIFT_RX_REPLY_EN
    assign w_unused_bits = ^{w_sclk_lvl, w_cs_lvl, w_sd_rise, w_sd_fall};
`else
    assign w_unused_bits = ^{w_sclk_lvl, w_cs_lvl, w_sd_rise, w_sd_fall,
                             w_sclk_fall};
`endif

    assign w_done   = (r_cnt == CNT_MAX);
    assign w_sample = (r_state == RX_SHIFT) && w_sclk_rise && !w_done;
    assign w_accept = r_valid && data_ready_in;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            RX_IDLE: begin
                w_cnt_nxt = '0;
                if (w_cs_fall) begin
                    w_state_nxt = RX_SHIFT;
                end
            end
            RX_SHIFT: begin
                if (w_done) begin
                    w_cnt_nxt = '0;
                end else if (w_sample) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
                // A final bit landing with cs_n rise still completes its word.
                if (w_cs_rise) begin
                    w_state_nxt = RX_IDLE;
                    if (!(w_sample && r_cnt == CNT_LAST)) begin
                        w_cnt_nxt = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = RX_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            r_state <= RX_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            r_shift <= '0;
        end else if (w_sample) begin
            r_shift <= {r_shift[WIDTH-2:0], w_sd};
        end
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            r_hold  <= '0;
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_ovr <= 1'b0;
            if (w_done) begin
                if (!r_valid || data_ready_in) begin
                    r_hold  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_ovr <= 1'b1;
                end
            end else if (w_accept) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign data_out       = r_valid ? r_hold : '0;
    assign data_valid_out = r_valid;
    assign overrun_out    = r_ovr;
    assign busy_out       = (r_state == RX_SHIFT);

`ifdef SHIFT_RX_REPLY_EN
    logic [WIDTH-1:0] r_tx;

    // The sclk fall right after a word boundary must not shift the reload.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            r_tx <= '0;
        end else if ((r_state == RX_IDLE && w_cs_fall) || w_done) begin
            r_tx <= tx_data_in;
        end else if (r_state == RX_SHIFT && w_sclk_fall && r_cnt != '0) begin
            r_tx <= {r_tx[WIDTH-2:0], 1'b0};
        end
    end

    assign sdata_out = (r_state == RX_SHIFT) && r_tx[WIDTH-1];
`endif

endmodule
